// File: rtl/memory_recall_unit.sv
// memory_recall_unit
// Read side of the calculator memory register. A memory-call press captures
// the stored number, converts it to BCD by serial shift-add-3, then streams
// the decimal digits (most significant first, leading zeros suppressed) over
// a valid/ready handshake.
module memory_recall_unit #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             memCall,
  input  logic [WIDTH-1:0] numberStore,
  input  logic             digitReady,
  output logic             digitValid,
  output logic [3:0]       digitOut,
  output logic             digitLast,
  output logic             busy,
  output logic             recallDone
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_EMIT    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Add 3 to every BCD nibble that is 5 or more (pre-shift correction).
  function automatic logic [BW-1:0] add3_nibbles(input logic [BW-1:0] bcd);
    logic [BW-1:0] res;
    logic [3:0]    nib;
    res = {BW{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      nib = bcd[i*4 +: 4];
      if (nib >= 4'd5) begin
        res[i*4 +: 4] = nib + 4'd3;
      end else begin
        res[i*4 +: 4] = nib;
      end
    end
    return res;
  endfunction

  // Index of the highest nonzero digit; 0 when the whole value is zero.
  function automatic logic [PW-1:0] top_digit(input logic [BW-1:0] bcd);
    logic [PW-1:0] p;
    p = {PW{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) begin
        p = PW'(i);
      end
    end
    return p;
  endfunction

  // Select one BCD digit by index.
  function automatic logic [3:0] pick_digit(input logic [BW-1:0] bcd,
                                            input logic [PW-1:0] p);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (p == PW'(i)) begin
        d = bcd[i*4 +: 4];
      end
    end
    return d;
  endfunction

  state_t            r_state;
  logic [WIDTH-1:0]  r_bin;
  logic [BW-1:0]     r_bcd;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_ptr;
  logic              r_mem_prev;
  logic              r_armed;
  logic              r_valid;
  logic [3:0]        r_digit;
  logic              r_last;
  logic              r_busy;
  logic              r_done;

  state_t            w_state_next;
  logic [WIDTH-1:0]  w_bin_next;
  logic [BW-1:0]     w_bcd_next;
  logic [CW-1:0]     w_cnt_next;
  logic [PW-1:0]     w_ptr_next;
  logic              w_armed_next;
  logic              w_valid_next;
  logic [3:0]        w_digit_next;
  logic              w_last_next;
  logic              w_done_next;
  logic              w_trigger;
  logic [BW+WIDTH-1:0] w_shift;
  logic [PW-1:0]     w_top;
  logic [PW-1:0]     w_ptr_dec;

  assign w_trigger = memCall & ~r_mem_prev;
  assign w_shift   = {add3_nibbles(r_bcd), r_bin} << 1'b1;
  assign w_top     = top_digit(r_bcd);
  assign w_ptr_dec = r_ptr - PW'(1);

  // Next-state and next-output logic for the recall sequence.
  always_comb begin
    w_state_next = r_state;
    w_bin_next   = r_bin;
    w_bcd_next   = r_bcd;
    w_cnt_next   = r_cnt;
    w_ptr_next   = r_ptr;
    w_armed_next = r_armed;
    w_valid_next = r_valid;
    w_digit_next = r_digit;
    w_last_next  = r_last;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_bin_next   = numberStore;
          w_bcd_next   = {BW{1'b0}};
          w_cnt_next   = {CW{1'b0}};
          w_state_next = S_CONVERT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_CONVERT: begin
        w_bcd_next = w_shift[BW+WIDTH-1:WIDTH];
        w_bin_next = w_shift[WIDTH-1:0];
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_armed_next = 1'b0;
          w_state_next = S_EMIT;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_EMIT: begin
        if (!r_armed) begin
          // First EMIT cycle: point at the leading digit and present it.
          w_ptr_next   = w_top;
          w_digit_next = pick_digit(r_bcd, w_top);
          w_last_next  = (w_top == {PW{1'b0}});
          w_valid_next = 1'b1;
          w_armed_next = 1'b1;
        end else if (r_valid && digitReady) begin
          if (r_ptr == {PW{1'b0}}) begin
            w_valid_next = 1'b0;
            w_digit_next = 4'd0;
            w_last_next  = 1'b0;
            w_done_next  = 1'b1;
            w_state_next = S_DONE;
          end else begin
            w_ptr_next   = w_ptr_dec;
            w_digit_next = pick_digit(r_bcd, w_ptr_dec);
            w_last_next  = (w_ptr_dec == {PW{1'b0}});
          end
        end else begin
          w_state_next = S_EMIT;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_valid_next = 1'b0;
        w_digit_next = 4'd0;
        w_last_next  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset aborts any recall.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bin      <= {WIDTH{1'b0}};
      r_bcd      <= {BW{1'b0}};
      r_cnt      <= {CW{1'b0}};
      r_ptr      <= {PW{1'b0}};
      r_mem_prev <= 1'b1;
      r_armed    <= 1'b0;
      r_valid    <= 1'b0;
      r_digit    <= 4'd0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bin      <= w_bin_next;
      r_bcd      <= w_bcd_next;
      r_cnt      <= w_cnt_next;
      r_ptr      <= w_ptr_next;
      r_mem_prev <= memCall;
      r_armed    <= w_armed_next;
      r_valid    <= w_valid_next;
      r_digit    <= w_digit_next;
      r_last     <= w_last_next;
      r_busy     <= (w_state_next != S_IDLE);
      r_done     <= w_done_next;
    end
  end

  assign digitValid = r_valid;
  assign digitOut   = r_digit;
  assign digitLast  = r_last;
  assign busy       = r_busy;
  assign recallDone = r_done;

endmodule

// File: tb/tb_memory_recall_unit.sv
// Testbench for memory_recall_unit: randomized and directed recalls checked
// against a decimal-formatting reference model.
module tb_memory_recall_unit;

  localparam int WIDTH  = 12;
  localparam int DIGITS = 4;
  localparam int LAT    = WIDTH + 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             memCall;
  logic [WIDTH-1:0] numberStore;
  logic             digitReady;
  logic             digitValid;
  logic [3:0]       digitOut;
  logic             digitLast;
  logic             busy;
  logic             recallDone;

  int total = 0;
  int bad   = 0;

  string obs_str;
  int    obs_len;
  int    obs_last_mask;
  int    obs_first_s;
  int    obs_done_s;
  int    obs_done_cnt;
  int    obs_busy_fall_s;
  int    obs_hold_bad;
  logic  obs_busy0;

  memory_recall_unit #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock       (clock),
    .reset       (reset),
    .memCall     (memCall),
    .numberStore (numberStore),
    .digitReady  (digitReady),
    .digitValid  (digitValid),
    .digitOut    (digitOut),
    .digitLast   (digitLast),
    .busy        (busy),
    .recallDone  (recallDone)
  );

  always #5 clock = ~clock;

  // Reference: decimal text of the value, no leading zeros, "0" for zero.
  function automatic string model_digits(input int v);
    return $sformatf("%0d", v);
  endfunction

  // Reference: sample index (after trigger edge) of the recallDone pulse.
  function automatic int model_done_s(input int n, input int stall);
    return LAT + n * (stall + 1);
  endfunction

  // Drive one recall and record what the DUT streams out.
  task automatic run_recall(input int val, input int stall, input int hold,
                            input int press2_at, input int change_at,
                            input int change_val, input int window);
    int         wait_n;
    logic [3:0] hold_digit;
    logic       hold_last;
    obs_str = ""; obs_len = 0; obs_last_mask = 0; obs_first_s = -1;
    obs_done_s = -1; obs_done_cnt = 0; obs_busy_fall_s = -1; obs_hold_bad = 0;
    obs_busy0 = 1'b0;
    wait_n = 0; hold_digit = 4'd0; hold_last = 1'b0;
    memCall = 1'b0;
    numberStore = WIDTH'(val);
    digitReady = (stall == 0);
    @(negedge clock);
    memCall = 1'b1;
    for (int s = 0; s < window; s++) begin
      @(negedge clock);
      if (s == 0) obs_busy0 = busy;
      if (recallDone === 1'b1) begin
        obs_done_cnt++;
        if (obs_done_s < 0) obs_done_s = s;
      end
      if (obs_done_s >= 0 && obs_busy_fall_s < 0 && busy === 1'b0) obs_busy_fall_s = s;
      if (digitValid === 1'b1) begin
        if (obs_first_s < 0) obs_first_s = s;
        if (wait_n == 0) begin
          hold_digit = digitOut;
          hold_last  = digitLast;
        end else if (digitOut !== hold_digit || digitLast !== hold_last) begin
          obs_hold_bad++;
        end
        if (wait_n >= stall) begin
          digitReady = 1'b1;
          if (digitLast === 1'b1) obs_last_mask |= (1 << obs_len);
          obs_str = {obs_str, $sformatf("%0d", digitOut)};
          obs_len++;
          wait_n = 0;
        end else begin
          digitReady = 1'b0;
          wait_n++;
        end
      end else begin
        digitReady = (stall == 0);
      end
      memCall = ((s + 2) <= hold) || (s == press2_at);
      if (s == change_at) numberStore = WIDTH'(change_val);
    end
    memCall = 1'b0;
    digitReady = 1'b0;
  endtask

  task automatic test_reset();
    int act;
    reset = 1'b1; memCall = 1'b1; digitReady = 1'b0; numberStore = {WIDTH{1'b0}};
    repeat (3) @(negedge clock);
    total++; if (digitValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", digitValid); end
    total++; if (digitOut !== 4'd0) begin bad++; $display("FAIL reset_digit: got %0d want 0", digitOut); end
    total++; if (digitLast !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", digitLast); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (recallDone !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", recallDone); end
    reset = 1'b0;
    act = 0;
    repeat (6) begin
      @(negedge clock);
      if (busy !== 1'b0 || digitValid !== 1'b0) act++;
    end
    total++; if (act !== 0) begin bad++; $display("FAIL reset_held_call: got %0d active cycles want 0", act); end
    memCall = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_max_value();
    string exp;
    exp = model_digits(4095);
    run_recall(4095, 0, 1, -1, -1, 0, 30);
    total++; if (obs_str != exp) begin bad++; $display("FAIL max_digits: got %s want %s", obs_str, exp); end
    total++; if (obs_busy0 !== 1'b1) begin bad++; $display("FAIL max_busy_start: got %b want 1", obs_busy0); end
    total++; if (obs_first_s !== LAT) begin bad++; $display("FAIL max_latency: got %0d want %0d", obs_first_s, LAT); end
    total++; if (obs_last_mask !== (1 << (exp.len() - 1))) begin bad++; $display("FAIL max_last: got %0h want %0h", obs_last_mask, 1 << (exp.len() - 1)); end
    total++; if (obs_done_s !== model_done_s(exp.len(), 0)) begin bad++; $display("FAIL max_done_time: got %0d want %0d", obs_done_s, model_done_s(exp.len(), 0)); end
    total++; if (obs_done_cnt !== 1) begin bad++; $display("FAIL max_done_count: got %0d want 1", obs_done_cnt); end
    total++; if (obs_busy_fall_s !== obs_done_s + 1) begin bad++; $display("FAIL max_busy_fall: got %0d want %0d", obs_busy_fall_s, obs_done_s + 1); end
  endtask

  task automatic test_patterns();
    int vals[3] = '{1000, 7, 0};
    string exp;
    foreach (vals[i]) begin
      exp = model_digits(vals[i]);
      run_recall(vals[i], 0, 1, -1, -1, 0, 30);
      total++; if (obs_str != exp) begin bad++; $display("FAIL pat_digits(%0d): got %s want %s", vals[i], obs_str, exp); end
      total++; if (obs_last_mask !== (1 << (exp.len() - 1))) begin bad++; $display("FAIL pat_last(%0d): got %0h want %0h", vals[i], obs_last_mask, 1 << (exp.len() - 1)); end
      total++; if (obs_done_s !== model_done_s(exp.len(), 0)) begin bad++; $display("FAIL pat_done_time(%0d): got %0d want %0d", vals[i], obs_done_s, model_done_s(exp.len(), 0)); end
      total++; if (obs_busy_fall_s !== model_done_s(exp.len(), 0) + 1) begin bad++; $display("FAIL pat_busy_fall(%0d): got %0d want %0d", vals[i], obs_busy_fall_s, model_done_s(exp.len(), 0) + 1); end
    end
  endtask

  task automatic test_random();
    int v;
    int st;
    string exp;
    for (int k = 0; k < 8; k++) begin
      v  = int'($urandom_range(0, 4095));
      st = int'($urandom_range(0, 3));
      exp = model_digits(v);
      run_recall(v, st, 1, -1, -1, 0, 40);
      total++; if (obs_str != exp) begin bad++; $display("FAIL rand_digits(%0d): got %s want %s", v, obs_str, exp); end
      total++; if (obs_done_s !== model_done_s(exp.len(), st)) begin bad++; $display("FAIL rand_done_time(%0d,%0d): got %0d want %0d", v, st, obs_done_s, model_done_s(exp.len(), st)); end
      total++; if (obs_hold_bad !== 0) begin bad++; $display("FAIL rand_hold(%0d): got %0d changes want 0", v, obs_hold_bad); end
    end
  endtask

  task automatic test_stall();
    string exp;
    exp = model_digits(305);
    run_recall(305, 5, 1, -1, -1, 0, 45);
    total++; if (obs_str != exp) begin bad++; $display("FAIL stall_digits: got %s want %s", obs_str, exp); end
    total++; if (obs_hold_bad !== 0) begin bad++; $display("FAIL stall_hold: got %0d changes want 0", obs_hold_bad); end
    total++; if (obs_len !== 3) begin bad++; $display("FAIL stall_transfers: got %0d want 3", obs_len); end
    total++; if (obs_done_cnt !== 1) begin bad++; $display("FAIL stall_done_count: got %0d want 1", obs_done_cnt); end
    total++; if (obs_done_s !== model_done_s(3, 5)) begin bad++; $display("FAIL stall_done_time: got %0d want %0d", obs_done_s, model_done_s(3, 5)); end
  endtask

  task automatic test_held_and_repress();
    run_recall(4095, 0, 40, -1, -1, 0, 70);
    total++; if (obs_str != "4095") begin bad++; $display("FAIL held_digits: got %s want 4095", obs_str); end
    total++; if (obs_done_cnt !== 1) begin bad++; $display("FAIL held_done_count: got %0d want 1", obs_done_cnt); end
    run_recall(4095, 0, 1, LAT + 1, -1, 0, 40);
    total++; if (obs_str != "4095") begin bad++; $display("FAIL repress_digits: got %s want 4095", obs_str); end
    total++; if (obs_done_cnt !== 1) begin bad++; $display("FAIL repress_done_count: got %0d want 1", obs_done_cnt); end
  endtask

  task automatic test_store_change();
    run_recall(123, 0, 1, -1, 5, 999, 40);
    total++; if (obs_str != model_digits(123)) begin bad++; $display("FAIL change_digits: got %s want 123", obs_str); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int act;
    numberStore = WIDTH'(4095); digitReady = 1'b1; memCall = 1'b0;
    @(negedge clock);
    memCall = 1'b1;
    @(negedge clock);
    memCall = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clock);
      if (digitValid === 1'b1) found = 1'b1;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL mid_wait_valid: got timeout want digitValid"); end
    total++; if (digitOut !== 4'd4) begin bad++; $display("FAIL mid_first_digit: got %0d want 4", digitOut); end
    @(negedge clock);
    total++; if (digitOut !== 4'd0 || digitValid !== 1'b1) begin bad++; $display("FAIL mid_second_digit: got %0d/%b want 0/1", digitOut, digitValid); end
    reset = 1'b1; memCall = 1'b1;
    @(negedge clock);
    total++; if ({digitValid, digitOut, digitLast, busy, recallDone} !== 8'd0) begin bad++; $display("FAIL mid_reset_outputs: got %b want 0", {digitValid, digitOut, digitLast, busy, recallDone}); end
    reset = 1'b0;
    act = 0;
    repeat (25) begin
      @(negedge clock);
      if (busy !== 1'b0 || digitValid !== 1'b0 || recallDone !== 1'b0) act++;
    end
    total++; if (act !== 0) begin bad++; $display("FAIL mid_no_recall: got %0d active cycles want 0", act); end
    run_recall(4095, 0, 1, -1, -1, 0, 30);
    total++; if (obs_str != "4095") begin bad++; $display("FAIL mid_restart_digits: got %s want 4095", obs_str); end
    total++; if (obs_first_s !== LAT) begin bad++; $display("FAIL mid_restart_latency: got %0d want %0d", obs_first_s, LAT); end
  endtask

  initial begin
    reset = 1'b1; memCall = 1'b0; digitReady = 1'b0; numberStore = {WIDTH{1'b0}};
    test_reset();
    test_max_value();
    test_patterns();
    test_random();
    test_stall();
    test_held_and_repress();
    test_store_change();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_recall_unit.md
Name: memory_recall_unit

Overview:
- Read side of the calculator memory register. On a memory-call press it captures the stored 12-bit number and converts it to BCD by serial shift-add-3 (double-dabble).
- It then streams the decimal digits, most significant first with leading zeros suppressed, to the operand entry/display path over a valid/ready handshake.
- Sits between the memory register output and the digit-entry logic. It replaces keypad digit entry while a recall is in progress.

Parameters:
- WIDTH, 12, bit width of the stored unsigned number.
- DIGITS, 4, number of BCD digits produced. Must be >= ceil(WIDTH*log10(2)); 4 for 12 bits, max value 4095.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- memCall  input  1  memory-call button level; may be held for many cycles.
- numberStore  input  WIDTH  value currently held in the memory register.
- digitReady  input  1  entry path can accept a digit this cycle.
- digitValid  output  1  digitOut holds a valid digit.
- digitOut  output  4  BCD digit, 0-9.
- digitLast  output  1  qualifies digitValid; the current digit is the least significant one.
- busy  output  1  recall in progress (CONVERT, EMIT or DONE).
- recallDone  output  1  one-cycle pulse after the last digit is accepted.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - digitValid, digitOut, digitLast, busy and recallDone all go to 0.
  - The shift/BCD registers are cleared.
  - The memCall edge-detect register is set to 1, so a button held through reset does not trigger a recall.
- Reset mid-operation aborts immediately. The captured value is discarded and no recallDone is issued.
- Edge detect: a trigger is memCall==1 while the previous sampled memCall==0. Holding memCall produces exactly one trigger.
- IDLE:
  - On a trigger, capture numberStore into the binary shift register and clear the BCD register.
  - Go to CONVERT; busy=1 from the next cycle.
  - Later changes to numberStore do not affect this recall.
- CONVERT, exactly WIDTH cycles:
  - Each cycle, add 3 to every BCD nibble that is >=5.
  - Then shift {BCD, binary} left by 1.
  - A bit counter runs from 0 to WIDTH-1. After the WIDTH-th update, go to EMIT.
- EMIT entry: the digit pointer is set to the highest nonzero digit, or digit 0 if the value is 0.
  - Leading zeros are suppressed; internal and trailing zeros are emitted.
  - Value 0 emits a single "0".
- EMIT handshake:
  - digitValid=1 and digitOut=BCD[pointer].
  - digitLast=1 when pointer==0.
  - A transfer occurs on a posedge with digitValid && digitReady.
  - digitOut and digitLast hold stable while digitReady is low; there is no timeout.
  - On transfer with pointer>0, the pointer decrements and the next digit is presented the following cycle with no bubble.
  - On transfer with pointer==0, digitValid drops and the state goes to DONE.
- DONE: recallDone=1 for exactly one cycle, busy still 1; then go to IDLE.
- Latency:
  - The first digitValid is seen WIDTH+1 cycles after the triggering posedge (13 for defaults).
  - The minimum total recall is 13 + n cycles plus 1 DONE cycle, where n is the number of digits.
- Triggers while busy are ignored and not queued; the edge register still tracks memCall.
- digitReady while digitValid is low has no effect.
- numberStore is treated as unsigned. All nibbles stay 0-9 by construction.

Test Plan:
- numberStore=4095, single memCall pulse, digitReady=1:
  - digits 4,0,9,5 on consecutive cycles.
  - First valid 13 cycles after the trigger; digitLast only on 5.
  - recallDone pulses on the following cycle.
- numberStore=1000 -> digits 1,0,0,0; internal zeros kept.
- numberStore=7 -> single digit 7 with digitLast=1.
- numberStore=0 -> single digit 0 with digitLast=1; busy drops 2 cycles after the transfer.
- numberStore=305, digitReady low for 5 cycles on each digit:
  - digitOut holds 3, then 0, then 5 unchanged while ready is low.
  - Exactly three transfers, one recallDone.
- memCall held high for 40 cycles, plus a second press during EMIT -> exactly one recall sequence and one recallDone.
- numberStore changed from 123 to 999 during CONVERT -> digits 1,2,3.
- Reset asserted mid-EMIT (after the first digit of 4095):
  - Next cycle all outputs are 0 and the state is IDLE.
  - memCall held high through and after reset causes no recall.
  - A fresh press restarts from digit 4.
